// File: rtl/pipe_pkg.sv
// Shared constants and next-state selection for the inter-stage pipeline registers.
// Exception codes follow the MIPS Cause.ExcCode numbering.
package pipe_pkg;

  localparam logic [31:0] PC_RESET_VAL  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0000;
  localparam int          EXC_W         = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    SEL_RESET,
    SEL_BUBBLE,
    SEL_HOLD,
    SEL_LOAD
  } stage_sel_e;

  // Priority: reset > flush > stall > load; an invalid upstream entry loads as a bubble.
  function automatic stage_sel_e pick_sel(input logic rst, input logic flush,
                                          input logic stall, input logic vld);
    if (rst)        return SEL_RESET;
    else if (flush) return SEL_BUBBLE;
    else if (stall) return SEL_HOLD;
    else if (!vld)  return SEL_BUBBLE;
    else            return SEL_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: valid bit plus instruction, PC, payload, exception code and delay-slot flag.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 96,
  parameter int EXC_W     = pipe_pkg::EXC_W
);
  logic                 valid;
  logic [31:0]          instr;
  logic [31:0]          pc;
  logic [PAYLOAD_W-1:0] payload;
  logic [EXC_W-1:0]     exc;
  logic                 bd;

  modport master (output valid, instr, pc, payload, exc, bd);
  modport slave  (input  valid, instr, pc, payload, exc, bd);
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (reset || clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/hold, flush/bubble and held status; 1-cycle latency.
// Define PIPE_PERF_EN to build the consecutive-stall and bubble counters; otherwise they read 0.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W = 96,
  parameter logic [31:0] PC_RST    = PC_RESET_VAL,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL,
  parameter int          EXC_W     = pipe_pkg::EXC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic              held_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  stage_sel_e sel;

  logic                 valid_d,   valid_q;
  logic [31:0]          instr_d,   instr_q;
  logic [31:0]          pc_d,      pc_q;
  logic [PAYLOAD_W-1:0] payload_d, payload_q;
  logic [EXC_W-1:0]     exc_d,     exc_q;
  logic                 bd_d,      bd_q;
  logic                 held_d,    held_q;

  assign sel = pick_sel(reset, flush_i, stall_i, up.valid);

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    payload_d = payload_q;
    exc_d     = exc_q;
    bd_d      = bd_q;
    held_d    = 1'b0;
    case (sel)
      SEL_RESET: begin
        valid_d   = 1'b0;
        instr_d   = NOP_INSTR;
        pc_d      = PC_RST;
        payload_d = '0;
        exc_d     = EXC_W'(EXC_NONE);
        bd_d      = 1'b0;
      end
      // A bubble keeps pc/bd so the EPC of a squashed slot still points at the right place.
      SEL_BUBBLE: begin
        valid_d   = 1'b0;
        instr_d   = NOP_INSTR;
        pc_d      = up.pc;
        payload_d = '0;
        exc_d     = EXC_W'(EXC_NONE);
        bd_d      = up.bd;
      end
      SEL_HOLD: begin
        held_d    = 1'b1;
      end
      default: begin
        valid_d   = 1'b1;
        instr_d   = up.instr;
        pc_d      = up.pc;
        payload_d = up.payload;
        exc_d     = up.exc;
        bd_d      = up.bd;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    instr_q   <= instr_d;
    pc_q      <= pc_d;
    payload_q <= payload_d;
    exc_q     <= exc_d;
    bd_q      <= bd_d;
    held_q    <= held_d;
  end

  assign dn.valid   = valid_q;
  assign dn.instr   = instr_q;
  assign dn.pc      = pc_q;
  assign dn.payload = payload_q;
  assign dn.exc     = exc_q;
  assign dn.bd      = bd_q;
  assign held_o     = held_q;

`ifdef PIPE_PERF_EN
  logic stall_edge;
  logic bubble_edge;

  assign stall_edge  = (sel == SEL_HOLD);
  assign bubble_edge = (sel == SEL_BUBBLE);

  pipe_sat_cnt #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_edge),
    .clr_i (!stall_edge),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(.W(32)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (bubble_edge),
    .clr_i (1'b0),
    .cnt_o (bubble_cnt_o)
  );
`else
  assign stall_cnt_o  = 32'h0;
  assign bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors push expected outputs, a monitor pops and compares.
module tb_pipe_stage_reg;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [95:0] payload;
    logic [4:0]  exc;
    logic        bd;
    logic        held;
    logic [31:0] scnt;
    logic [31:0] bcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        held_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] bubble_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  pipe_stage_reg_if #(.PAYLOAD_W(96), .EXC_W(5)) up_if ();
  pipe_stage_reg_if #(.PAYLOAD_W(96), .EXC_W(5)) dn_if ();

  pipe_stage_reg #(
    .PAYLOAD_W (96),
    .PC_RST    (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000),
    .EXC_W     (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .up           (up_if.slave),
    .dn           (dn_if.master),
    .held_o       (held_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] c(input logic [31:0] n);
    return PERF ? n : 32'h0;
  endfunction

  task automatic chk(input string name, input int idx, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h want %h", idx, name, act, exp);
    end
  endtask

  // Drive one edge's inputs and queue what the outputs must show after that edge.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [95:0] pl, input logic [4:0] ex, input logic bd,
                      input logic e_v, input logic [31:0] e_ins, input logic [31:0] e_pc,
                      input logic [95:0] e_pl, input logic [4:0] e_ex, input logic e_bd,
                      input logic e_held, input logic [31:0] e_sc, input logic [31:0] e_bc);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    stall_i       = st;
    flush_i       = fl;
    up_if.valid   = v;
    up_if.instr   = ins;
    up_if.pc      = pc;
    up_if.payload = pl;
    up_if.exc     = ex;
    up_if.bd      = bd;
    e.vld = e_v; e.instr = e_ins; e.pc = e_pc; e.payload = e_pl; e.exc = e_ex;
    e.bd = e_bd; e.held = e_held; e.scnt = e_sc; e.bcnt = e_bc;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge produces one registered output set, checked 1ns after the edge.
  initial begin : monitor
    int idx = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("valid_o",      idx, {95'b0, dn_if.valid}, {95'b0, e.vld});
        chk("instr_o",      idx, {64'b0, dn_if.instr}, {64'b0, e.instr});
        chk("pc_o",         idx, {64'b0, dn_if.pc},    {64'b0, e.pc});
        chk("payload_o",    idx, dn_if.payload,        e.payload);
        chk("exc_o",        idx, {91'b0, dn_if.exc},   {91'b0, e.exc});
        chk("bd_o",         idx, {95'b0, dn_if.bd},    {95'b0, e.bd});
        chk("held_o",       idx, {95'b0, held_o},      {95'b0, e.held});
        chk("stall_cnt_o",  idx, {64'b0, stall_cnt_o}, {64'b0, e.scnt});
        chk("bubble_cnt_o", idx, {64'b0, bubble_cnt_o},{64'b0, e.bcnt});
        idx++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [95:0] pa;
    pa = {12{8'hA5}};
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    up_if.valid = 1'b0; up_if.instr = '0; up_if.pc = '0;
    up_if.payload = '0; up_if.exc = '0; up_if.bd = 1'b0;

    // Reset for two edges; the first also has a stall and live inputs, which reset overrides.
    step(1,1,0, 1,32'hDEAD_BEEF,32'h4000,pa,5'd5,1,  0,32'h0,32'h3000,96'h0,5'd0,0, 0,32'h0,32'h0);
    step(1,0,0, 0,32'h0,32'h0,96'h0,5'd0,0,           0,32'h0,32'h3000,96'h0,5'd0,0, 0,32'h0,32'h0);
    // Plain load.
    step(0,0,0, 1,32'h2408_0005,32'h3004,pa,5'd0,0,   1,32'h2408_0005,32'h3004,pa,5'd0,0, 0,32'h0,32'h0);
    // Three stall edges with changing inputs: outputs frozen.
    for (int i = 0; i < 3; i++) begin
      step(0,1,0, 1,32'hFFFF_FFFF,32'h3100 + 32'(i),~pa,5'd3,1,
           1,32'h2408_0005,32'h3004,pa,5'd0,0, 1,c(32'(i + 1)),32'h0);
    end
    // Release: new load, stall counter clears.
    step(0,0,0, 1,32'h1111_2222,32'h3008,96'h1,5'd0,0, 1,32'h1111_2222,32'h3008,96'h1,5'd0,0, 0,32'h0,32'h0);
    // Flush and stall together: flush wins, pc/bd pass through.
    step(0,1,1, 1,32'h2222_3333,32'h3008,96'h2,5'd4,1, 0,32'h0,32'h3008,96'h0,5'd0,1, 0,32'h0,c(1));
    // Exception carried by a valid entry, then dropped by an invalid one.
    step(0,0,0, 1,32'h0000_000C,32'h300C,96'h5,5'd12,0, 1,32'h0000_000C,32'h300C,96'h5,5'd12,0, 0,32'h0,c(1));
    step(0,0,0, 0,32'h0000_000C,32'h3010,96'h5,5'd12,1, 0,32'h0,32'h3010,96'h0,5'd0,1, 0,32'h0,c(2));
    // Stall while holding a bubble.
    step(0,1,0, 1,32'h3333_4444,32'h3014,96'h7,5'd1,0, 0,32'h0,32'h3010,96'h0,5'd0,1, 1,c(1),c(2));
    // Reset while stalled: reset wins and clears counters.
    step(1,1,0, 1,32'h5555_6666,32'h3018,96'h9,5'd2,1, 0,32'h0,32'h3000,96'h0,5'd0,0, 0,32'h0,32'h0);
    step(0,0,0, 1,32'h2408_0005,32'h301C,pa,5'd4,1,   1,32'h2408_0005,32'h301C,pa,5'd4,1, 0,32'h0,32'h0);

`ifdef PIPE_PERF_EN
    // Preload the bubble counter near the top, then insert three bubbles.
    @(posedge clk);
    #2;
    force dut.u_bubble_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_bubble_cnt.cnt_q;
    step(0,0,1, 1,32'h7777_0000,32'h3020,96'h3,5'd0,0, 0,32'h0,32'h3020,96'h0,5'd0,0, 0,32'h0,32'hFFFF_FFFF);
    step(0,0,0, 0,32'h7777_0001,32'h3024,96'h3,5'd0,1, 0,32'h0,32'h3024,96'h0,5'd0,1, 0,32'h0,32'hFFFF_FFFF);
    step(0,1,1, 1,32'h7777_0002,32'h3028,96'h3,5'd0,0, 0,32'h0,32'h3028,96'h0,5'd0,0, 0,32'h0,32'hFFFF_FFFF);
`endif

    // Let the monitor drain the last entry, then confirm nothing is left unchecked.
    @(posedge clk);
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
